// File: rtl/maze_tile_renderer.sv
// Procedural 40x30 maze tile renderer: loads the maze ROM into a tile RAM, serves game tile edits, renders 8-bit RGB 3 cycles after row/col.
// Optional POWER_BLINK_EN: power pellets blink every 16 frames via a 5-bit frame counter.
module maze_tile_renderer #(
  parameter int TILE_COLS = 40,
  parameter int TILE_ROWS = 30,
  parameter int PELLET_W  = 11
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [5:0]          row,
  input  logic [5:0]          col,
  input  logic [4:0]          square_y,
  input  logic [4:0]          square_x,
  input  logic                video_on,
  input  logic                frame_tick,
  input  logic                reload,
  input  logic                wr_req,
  input  logic [5:0]          wr_row,
  input  logic [5:0]          wr_col,
  input  logic [2:0]          wr_code,
  output logic                wr_ack,
  output logic                ready,
  output logic [PELLET_W-1:0] pellets_left,
  output logic [7:0]          VGA_R,
  output logic [7:0]          VGA_G,
  output logic [7:0]          VGA_B
);

  localparam int DEPTH = TILE_COLS * TILE_ROWS;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [PELLET_W-1:0] CNT_MAX = '1;
  localparam logic [23:0] BLACK = 24'h000000;
  localparam logic [23:0] BLUE  = 24'h2121DE;
  localparam logic [23:0] PEACH = 24'hFFB897;
  localparam logic [23:0] PINK  = 24'hFFB8DE;

  typedef enum logic {LOAD, RUN} state_t;

  state_t                state_q;
  logic [AW-1:0]         ld_addr_q;
  logic [5:0]            ld_row_q, ld_col_q;
  logic                  ready_q, wr_ack_q;
  logic [PELLET_W-1:0]   pellets_q;
  logic [2:0]            mem [DEPTH];

  logic [2:0]            s1_code_q, s2_code_q;
  logic [3:0]            sx_q, sy_q;
  logic [23:0]           rgb_q, rgb_d;
  logic                  pp_on;

  // Constant maze image: border walls, pillar grid, ghost-house corridor with door, four power pellets.
  function automatic logic [2:0] maze_rom(input logic [5:0] r, input logic [5:0] c);
    logic [2:0] code;
    if (r == 6'd0 || r == 6'(TILE_ROWS-1) || c == 6'd0 || c == 6'(TILE_COLS-1))
      code = 3'd1;
    else if (r == 6'd14 && (c == 6'd19 || c == 6'd20))
      code = 3'd4;
    else if (r == 6'd14 && c >= 6'd15 && c <= 6'd24)
      code = 3'd0;
    else if ((r == 6'd2 || r == 6'(TILE_ROWS-3)) && (c == 6'd2 || c == 6'(TILE_COLS-3)))
      code = 3'd3;
    else if (r[1:0] == 2'd2 && c[1:0] == 2'd2)
      code = 3'd1;
    else
      code = 3'd2;
    return code;
  endfunction

  function automatic logic [11:0] addr_of(input logic [5:0] r, input logic [5:0] c);
    return {6'd0, r} * 12'(TILE_COLS) + {6'd0, c};
  endfunction

  logic [11:0]   rd_full, wr_full;
  logic [AW-1:0] rd_addr, wr_addr;
  logic          rd_in_range, wr_in_range, wr_fire;
  logic [2:0]    wr_old, rom_code;
  logic          old_pel, new_pel, rom_pel;

  assign rd_full     = addr_of(row, col);
  assign wr_full     = addr_of(wr_row, wr_col);
  assign rd_addr     = rd_full[AW-1:0];
  assign wr_addr     = wr_full[AW-1:0];
  assign rd_in_range = (row < 6'(TILE_ROWS)) && (col < 6'(TILE_COLS));
  assign wr_in_range = (wr_row < 6'(TILE_ROWS)) && (wr_col < 6'(TILE_COLS));
  // wr_ack_q gates the cycle after an accept so a level-held request is not written twice back to back.
  assign wr_fire     = (state_q == RUN) && wr_req && !wr_ack_q && !reload;
  assign wr_old      = wr_in_range ? mem[wr_addr] : 3'd0;
  assign old_pel     = (wr_old == 3'd2) || (wr_old == 3'd3);
  assign new_pel     = (wr_code == 3'd2) || (wr_code == 3'd3);
  assign rom_code    = maze_rom(ld_row_q, ld_col_q);
  assign rom_pel     = (rom_code == 3'd2) || (rom_code == 3'd3);

  always_ff @(posedge HCLK) begin
    if (state_q == LOAD && !reload)
      mem[ld_addr_q] <= rom_code;
    else if (wr_fire && wr_in_range)
      mem[wr_addr] <= wr_code;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= LOAD;
      ld_addr_q <= '0;
      ld_row_q  <= '0;
      ld_col_q  <= '0;
      ready_q   <= 1'b0;
      wr_ack_q  <= 1'b0;
      pellets_q <= '0;
    end else begin
      wr_ack_q <= 1'b0;
      if (reload) begin
        state_q   <= LOAD;
        ld_addr_q <= '0;
        ld_row_q  <= '0;
        ld_col_q  <= '0;
        ready_q   <= 1'b0;
        pellets_q <= '0;
      end else if (state_q == LOAD) begin
        if (rom_pel && pellets_q != CNT_MAX)
          pellets_q <= pellets_q + PELLET_W'(1);
        if (ld_addr_q == AW'(DEPTH-1)) begin
          state_q   <= RUN;
          ready_q   <= 1'b1;
          ld_addr_q <= '0;
          ld_row_q  <= '0;
          ld_col_q  <= '0;
        end else begin
          ld_addr_q <= ld_addr_q + AW'(1);
          if (ld_col_q == 6'(TILE_COLS-1)) begin
            ld_col_q <= '0;
            ld_row_q <= ld_row_q + 6'd1;
          end else begin
            ld_col_q <= ld_col_q + 6'd1;
          end
        end
      end else if (wr_fire) begin
        wr_ack_q <= 1'b1;
        if (wr_in_range) begin
          if (old_pel && !new_pel && pellets_q != '0)
            pellets_q <= pellets_q - PELLET_W'(1);
          else if (!old_pel && new_pel && pellets_q != CNT_MAX)
            pellets_q <= pellets_q + PELLET_W'(1);
        end
      end
    end
  end

`ifdef POWER_BLINK_EN
  logic [4:0] frame_cnt_q;
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)
      frame_cnt_q <= '0;
    else if (frame_tick)
      frame_cnt_q <= frame_cnt_q + 5'd1;
  end
  assign pp_on = ~frame_cnt_q[4];
`else
  assign pp_on = 1'b1;
`endif

  // Out-of-map coordinates read as empty so they fall through to black.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s1_code_q <= '0;
      s2_code_q <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      rgb_q     <= BLACK;
    end else begin
      s1_code_q <= rd_in_range ? mem[rd_addr] : 3'd0;
      s2_code_q <= s1_code_q;
      sx_q      <= square_x[3:0];
      sy_q      <= square_y[3:0];
      rgb_q     <= rgb_d;
    end
  end

  logic wall_edge, dot_hit, power_hit, door_hit;
  assign wall_edge = (sx_q < 4'd2) || (sx_q > 4'd13) || (sy_q < 4'd2) || (sy_q > 4'd13);
  assign dot_hit   = (sx_q inside {[4'd7:4'd8]}) && (sy_q inside {[4'd7:4'd8]});
  assign power_hit = (sx_q inside {[4'd4:4'd11]}) && (sy_q inside {[4'd4:4'd11]});
  assign door_hit  = sy_q inside {[4'd7:4'd8]};

  always_comb begin
    rgb_d = BLACK;
    case (s2_code_q)
      3'd1:    if (wall_edge) rgb_d = BLUE;
      3'd2:    if (dot_hit) rgb_d = PEACH;
      3'd3:    if (power_hit && pp_on) rgb_d = PEACH;
      3'd4:    if (door_hit) rgb_d = PINK;
      default: rgb_d = BLACK;
    endcase
    if (!video_on || !ready_q)
      rgb_d = BLACK;
  end

  logic unused_ok;
  assign unused_ok = ^{square_x[4], square_y[4], frame_tick, rd_full[11], wr_full[11]};

  assign wr_ack       = wr_ack_q;
  assign ready        = ready_q;
  assign pellets_left = pellets_q;
  assign VGA_R        = rgb_q[23:16];
  assign VGA_G        = rgb_q[15:8];
  assign VGA_B        = rgb_q[7:0];

endmodule

// File: tb/tb_maze_tile_renderer.sv
// Randomized scoreboard bench for maze_tile_renderer against a tile-map reference model.
module tb_maze_tile_renderer;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [5:0]  row = '0, col = '0;
  logic [4:0]  square_y = '0, square_x = '0;
  logic        video_on = 1'b0, frame_tick = 1'b0, reload = 1'b0, wr_req = 1'b0;
  logic [5:0]  wr_row = '0, wr_col = '0;
  logic [2:0]  wr_code = '0;
  logic        wr_ack, ready;
  logic [10:0] pellets_left;
  logic [7:0]  VGA_R, VGA_G, VGA_B;

  maze_tile_renderer dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .row(row), .col(col),
    .square_y(square_y), .square_x(square_x), .video_on(video_on),
    .frame_tick(frame_tick), .reload(reload), .wr_req(wr_req),
    .wr_row(wr_row), .wr_col(wr_col), .wr_code(wr_code), .wr_ack(wr_ack),
    .ready(ready), .pellets_left(pellets_left),
    .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: actual 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: the maze as a 2-D picture, painted layer by layer.
  int map [30][40];
  int model_pellets;
  int ticks = 0;

  function automatic void paint_maze();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++)
        map[r][c] = (r == 0 || r == 29 || c == 0 || c == 39) ? 1 : 2;
    for (int r = 2; r < 29; r += 4)
      for (int c = 2; c < 39; c += 4)
        map[r][c] = 1;
    for (int c = 15; c <= 24; c++) map[14][c] = 0;
    map[14][19] = 4;
    map[14][20] = 4;
    map[2][2] = 3; map[2][37] = 3; map[27][2] = 3; map[27][37] = 3;
    model_pellets = 0;
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++)
        if (map[r][c] == 2 || map[r][c] == 3) model_pellets++;
  endfunction

  function automatic logic [23:0] exp_rgb(int r, int c, int sx, int sy, bit vid);
    int code, x, y;
    bit pwr_on;
`ifdef POWER_BLINK_EN
    pwr_on = (ticks % 32) < 16;
`else
    pwr_on = 1'b1;
`endif
    if (!vid || r >= 30 || c >= 40) return 24'h0;
    code = map[r][c];
    x = sx % 16;
    y = sy % 16;
    if (code == 1 && (x <= 1 || x >= 14 || y <= 1 || y >= 14)) return 24'h2121DE;
    if (code == 2 && x >= 7 && x <= 8 && y >= 7 && y <= 8) return 24'hFFB897;
    if (code == 3 && pwr_on && x >= 4 && x <= 11 && y >= 4 && y <= 11) return 24'hFFB897;
    if (code == 4 && y >= 7 && y <= 8) return 24'hFFB8DE;
    return 24'h0;
  endfunction

  typedef struct { int due; logic [23:0] rgb; } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  always @(negedge HCLK) begin
    if (exp_q.size() > 0) begin
      if (exp_q[0].due < cyc) begin
        mon_e = exp_q.pop_front();
        check("rgb_slot", cyc, mon_e.due);
      end else if (exp_q[0].due == cyc) begin
        mon_e = exp_q.pop_front();
        check("rgb", {VGA_R, VGA_G, VGA_B}, mon_e.rgb);
      end
    end
  end

  int dir_r [6] = '{1, 0, 2, 14, 6, 27};
  int dir_c [6] = '{1, 5, 2, 19, 6, 37};

  // Streams n pixels: row/col now, square one cycle later, video_on two cycles later.
  task automatic run_pixels(input int n, input bit power_only);
    int psx [1024];
    int psy [1024];
    bit pvid [1024];
    int r, c, k2;
    for (int k = 0; k < n + 2; k++) begin
      @(posedge HCLK); #1;
      if (k < n) begin
        if (power_only) begin
          k2 = $urandom_range(0, 1);
          r = (k2 == 0) ? 2 : 27;
          c = ($urandom_range(0, 1) == 0) ? 2 : 37;
          psx[k] = $urandom_range(4, 11) + 16 * $urandom_range(0, 1);
          psy[k] = $urandom_range(4, 11);
          pvid[k] = 1'b1;
        end else begin
          if ($urandom_range(0, 3) == 0) begin
            k2 = $urandom_range(0, 5);
            r = dir_r[k2];
            c = dir_c[k2];
          end else begin
            r = $urandom_range(0, 33);
            c = $urandom_range(0, 43);
          end
          psx[k] = $urandom_range(0, 31);
          psy[k] = $urandom_range(0, 31);
          pvid[k] = ($urandom_range(0, 7) != 0);
        end
        row = 6'(r);
        col = 6'(c);
        exp_q.push_back('{cyc + 3, exp_rgb(r, c, psx[k], psy[k], pvid[k])});
      end
      if (k >= 1 && k <= n) begin
        square_x = 5'(psx[k-1]);
        square_y = 5'(psy[k-1]);
      end
      if (k >= 2) video_on = pvid[k-2];
    end
    @(posedge HCLK); #1;
    video_on = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge HCLK);
    #1;
  endtask

  task automatic model_write(input int r, input int c, input int code);
    bit oldp, newp;
    if (r < 30 && c < 40) begin
      oldp = (map[r][c] == 2 || map[r][c] == 3);
      newp = (code == 2 || code == 3);
      if (oldp && !newp && model_pellets > 0) model_pellets--;
      else if (!oldp && newp && model_pellets < 2047) model_pellets++;
      map[r][c] = code;
    end
  endtask

  task automatic do_write(input int r, input int c, input int code);
    int n = 0;
    bit got = 1'b0;
    wr_row = 6'(r); wr_col = 6'(c); wr_code = 3'(code); wr_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge HCLK); #1;
      n++;
      if (wr_ack) got = 1'b1;
    end
    wr_req = 1'b0;
    check("wr_ack_latency", got ? n : -1, 1);
    model_write(r, c, code);
    check("pellets_after_write", {21'd0, pellets_left}, model_pellets);
    @(posedge HCLK); #1;
    check("wr_ack_one_cycle", {31'd0, wr_ack}, 0);
  endtask

  // Counts cycles until ready while driving live pixel traffic; RGB must stay black meanwhile.
  task automatic wait_ready(output int n);
    int bad = 0;
    n = 0;
    video_on = 1'b1;
    while (!ready && n < 1400) begin
      row = 6'($urandom_range(0, 29));
      col = 6'($urandom_range(0, 39));
      square_x = 5'($urandom_range(0, 31));
      square_y = 5'($urandom_range(0, 31));
      @(posedge HCLK); #1;
      n++;
      if (!ready && {VGA_R, VGA_G, VGA_B} != 24'h0) bad++;
    end
    video_on = 1'b0;
    check("rgb_black_in_load", bad, 0);
  endtask

  task automatic pulse_frames(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge HCLK); #1; frame_tick = 1'b1;
      @(posedge HCLK); #1; frame_tick = 1'b0;
      ticks++;
    end
  endtask

  initial begin
    int n, n_rdy, n_ack;
    paint_maze();
    repeat (3) @(posedge HCLK);
    #1;
    check("reset_ready", {31'd0, ready}, 0);
    check("reset_wr_ack", {31'd0, wr_ack}, 0);
    check("reset_pellets", {21'd0, pellets_left}, 0);
    check("reset_rgb", {VGA_R, VGA_G, VGA_B}, 0);

    HRESETn = 1'b1;
    wait_ready(n);
    check("load_cycles", n, 1200);
    check("pellets_loaded", {21'd0, pellets_left}, model_pellets);

    run_pixels(300, 1'b0);

    do_write(1, 1, 0);
    do_write(0, 45, 2);
    do_write(14, 15, 3);
    do_write(27, 37, 0);
    do_write(6, 6, 2);
    for (int i = 0; i < 8; i++)
      do_write($urandom_range(0, 31), $urandom_range(0, 41), $urandom_range(0, 7));
    run_pixels(300, 1'b0);

    // Reload from RUN, then reload again roughly halfway through the walk.
    reload = 1'b1;
    @(posedge HCLK); #1;
    reload = 1'b0;
    check("ready_drop_on_reload", {31'd0, ready}, 0);
    repeat (600) @(posedge HCLK);
    #1;
    reload = 1'b1;
    @(posedge HCLK); #1;
    reload = 1'b0;
    paint_maze();
    wait_ready(n);
    check("reload_cycles", n, 1200);
    check("pellets_reloaded", {21'd0, pellets_left}, model_pellets);

    // reload wins over a simultaneous write; the held request is served once RUN is reached.
    reload = 1'b1;
    wr_row = 6'd1; wr_col = 6'd1; wr_code = 3'd0; wr_req = 1'b1;
    @(posedge HCLK); #1;
    reload = 1'b0;
    check("reload_beats_write_ack", {31'd0, wr_ack}, 0);
    n_rdy = -1;
    n_ack = -1;
    for (int i = 1; i <= 1400 && n_ack < 0; i++) begin
      @(posedge HCLK); #1;
      if (ready && n_rdy < 0) n_rdy = i;
      if (wr_ack) n_ack = i;
    end
    wr_req = 1'b0;
    check("held_write_ready_at", n_rdy, 1200);
    check("held_write_ack_at", n_ack, 1201);
    model_write(1, 1, 0);
    check("pellets_held_write", {21'd0, pellets_left}, model_pellets);
    run_pixels(200, 1'b0);

    run_pixels(16, 1'b1);
    pulse_frames(16);
    run_pixels(16, 1'b1);
    pulse_frames(16);
    run_pixels(16, 1'b1);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
